bench_multi_arb_monitor: RTL and testbench
==========================================

Name: bench_multi_arb_monitor

Overview:
- Parametrised N-channel successor to the single-channel response/error synthesis benchmark.
- Environment drives per-channel requests. The synthesised controller drives per-channel grants.
- Block counts served responses per channel inside a sliding accounting window. It flags a sticky error on any safety violation.
- Instantiated as the top-level benchmark module under the model-checking / reactive-synthesis flow; `_rt_get` exposes the uncontrollable inputs to the tool.

Parameters:
- N_CH, 4, number of request/grant channels (1..8)
- CNT_W, 3, width of per-channel serve and wait counters (saturating)
- MAX_SERVE, 4, serve count at which a denied request is an error (must be < 2**CNT_W)
- MAX_WAIT, 3, consecutive denied-request cycles that constitute starvation (optional feature only)
- WIN_LEN, 16, accounting window length in cycles (>= 2)

Ports:
- clk  in  1  benchmark clock, all state on posedge
- rst  in  1  synchronous active-high reset
- req  in  N_CH  per-channel request, uncontrollable environment input
- grant  in  N_CH  per-channel grant, controllable input (synthesised controller)
- error  out  1  sticky safety-violation flag, registered
- err_code  out  3  cause of first violation, registered
- busy  out  N_CH  registered copy of (req & grant) from previous cycle
- _rt_get  out  N_CH  combinational copy of req

Behaviour:
- Reset (rst=1 at posedge) sets the following; rst takes priority over all other updates.
  - state=RUN
  - all cnt[c], wait[c], win = 0
  - error=0, err_code=0 (NONE), busy=0
- Response: resp[c] = req[c] & grant[c]. In RUN, cnt[c] increments on resp[c] and saturates at 2**CNT_W-1.
- Window:
  - win counts 0..WIN_LEN-1 and wraps to 0.
  - On the wrap cycle, every cnt[c] is cleared. Clear beats a same-cycle increment, so cnt=0, not 1.
- Wait:
  - wait[c] increments while req[c] & !grant[c], saturating.
  - wait[c] clears on !req[c] or grant[c].
- Violations are evaluated combinationally on current inputs and pre-update counters:
  - MUTEX (code 1): popcount(grant) > 1.
  - SPUR (code 2): any grant[c] & !req[c].
  - DENY (code 3): any cnt[c] >= MAX_SERVE & req[c] & !grant[c].
  - STARVE (code 4): see Optional Feature.
- Priority when simultaneous: MUTEX > SPUR > DENY > STARVE. Only the highest is recorded.
- FSM has two states:
  - RUN -> FAIL at posedge when any violation is true.
  - FAIL is absorbing until rst.
  - In FAIL, cnt, wait, win and err_code are frozen.
- error = (state==FAIL), so it rises exactly 1 cycle after the violating sample.
- err_code is loaded on the RUN->FAIL edge only.
- busy updates every cycle, including in FAIL.
- _rt_get has zero latency and is unaffected by rst.
- Reset mid-operation: the next cycle is indistinguishable from power-up. Window phase restarts at 0.

Optional Feature:
- Macro: BENCH_MULTI_ARB_STARVE_EN.
- Defined: STARVE (code 4) is true when any wait[c] == MAX_WAIT-1 and req[c] & !grant[c] in the current cycle, i.e. the MAX_WAIT-th consecutive denial.
- Undefined:
  - wait counters are not instantiated.
  - STARVE is never raised.
  - code 4 is unreachable.

Decomposition:
- Package bench_multi_arb_pkg holds:
  - err_code enum: NONE=0, MUTEX=1, SPUR=2, DENY=3, STARVE=4
  - FSM state enum: RUN, FAIL
  - localparam for ERR_W=3
- Sub-module bench_chan_ctr (one instance per channel) holds:
  - serve counter with window clear and saturation
  - wait counter
  - per-channel DENY/SPUR/STARVE terms
- Top level holds:
  - MUTEX check
  - priority encode
  - FSM
  - window counter

Test Plan:
- rst=1 for 2 cycles, then req=0, grant=0 for 20 cycles -> error=0, err_code=0, busy=0 throughout.
- Channel 0: req=1, grant=1 for 4 cycles, then req=1, grant=0 -> error=1 one cycle after the deny, err_code=3. Other channels unaffected.
- Channel 0 serves 4 times, window wraps (cycle 15), then denied on cycle 16 -> no error, because cnt was cleared at the wrap.
- req=4'b0011, grant=4'b0011 simultaneous with grant=4'b0100 spurious -> err_code=1 (MUTEX beats SPUR), error=1.
- Inject DENY, hold 5 cycles, assert rst for 1 cycle, then legal traffic -> error=0, err_code=0 after reset, and the window restarts at 0.
- With BENCH_MULTI_ARB_STARVE_EN, channel 2 req=1, grant=0, cnt=0 for 3 cycles -> error=1 on cycle 4, err_code=4. Without the macro -> no error.

Source files
------------

// File: rtl/bench_multi_arb_pkg.sv
// Shared types for the multi-channel arbitration monitor: error codes, FSM states
// and the violation priority encoder.
package bench_multi_arb_pkg;

    localparam int unsigned ERR_W = 3;

    typedef enum logic [ERR_W-1:0] {
        NONE   = 3'd0,
        MUTEX  = 3'd1,
        SPUR   = 3'd2,
        DENY   = 3'd3,
        STARVE = 3'd4
    } err_code_e;

    typedef enum logic {
        RUN  = 1'b0,
        FAIL = 1'b1
    } state_e;

    // Highest-priority violation wins: MUTEX > SPUR > DENY > STARVE.
    function automatic err_code_e err_prio(input logic mutex, input logic spur,
                                           input logic deny, input logic starve);
        if (mutex)  return MUTEX;
        if (spur)   return SPUR;
        if (deny)   return DENY;
        if (starve) return STARVE;
        return NONE;
    endfunction

endpackage

// File: rtl/bench_multi_arb_monitor_if.sv
// Request/grant bus seen by the arbitration monitor; master is the environment
// plus controller side, slave is the monitor.
interface bench_multi_arb_monitor_if
    import bench_multi_arb_pkg::*;
#(
    parameter int unsigned N_CH = 4
) ();

    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant;
    logic            error;
    err_code_e       err_code;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] _rt_get;

    modport master (
        output req, grant,
        input  error, err_code, busy, _rt_get
    );

    modport slave (
        input  req, grant,
        output error, err_code, busy, _rt_get
    );

endinterface

// File: rtl/bench_chan_ctr.sv
// Per-channel serve/wait accounting and per-channel violation terms.
// Wait counter and STARVE term exist only with BENCH_MULTI_ARB_STARVE_EN defined.
module bench_chan_ctr #(
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned MAX_SERVE = 4
`ifdef BENCH_MULTI_ARB_STARVE_EN
  , parameter int unsigned MAX_WAIT  = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic wrap,
    input  logic req,
    input  logic grant,
    output logic deny_c,
    output logic spur_c,
    output logic starve_c
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] SERVE_LIM = CNT_W'(MAX_SERVE);

    logic [CNT_W-1:0] cnt;
    logic             resp_c;
    logic             denied_c;

    assign resp_c   = req & grant;
    assign denied_c = req & ~grant;

    // Window clear takes precedence over a same-cycle serve.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (run) begin
            if (wrap) begin
                cnt <= '0;
            end else if (resp_c && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign deny_c = (cnt >= SERVE_LIM) & denied_c;
    assign spur_c = grant & ~req;

`ifdef BENCH_MULTI_ARB_STARVE_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (run) begin
            if (!denied_c) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Fires on the MAX_WAIT-th consecutive denial.
    assign starve_c = (wait_cnt == WAIT_LAST) & denied_c;
`else
    assign starve_c = 1'b0;
`endif

endmodule

// File: rtl/bench_multi_arb_monitor.sv
// N-channel arbitration safety monitor: window accounting, violation priority and
// sticky RUN/FAIL FSM. Optional starvation check: BENCH_MULTI_ARB_STARVE_EN.
module bench_multi_arb_monitor
    import bench_multi_arb_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned MAX_SERVE = 4,
`ifdef BENCH_MULTI_ARB_STARVE_EN
    parameter int unsigned MAX_WAIT  = 3,
`endif
    parameter int unsigned WIN_LEN   = 16
) (
    input logic                     clk,
    input logic                     rst,
    bench_multi_arb_monitor_if.slave bus
);

    localparam int unsigned WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    state_e          state;
    logic [WIN_W-1:0] win;
    err_code_e       err_code_q;
    logic [N_CH-1:0] busy_q;

    logic            run_c;
    logic            wrap_c;
    logic            mutex_c;
    logic            viol_c;
    err_code_e       code_c;
    logic [N_CH-1:0] deny_c;
    logic [N_CH-1:0] spur_c;
    logic [N_CH-1:0] starve_c;

    assign run_c  = (state == RUN);
    assign wrap_c = (win == WIN_LAST);

    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        bench_chan_ctr #(
            .CNT_W     (CNT_W),
            .MAX_SERVE (MAX_SERVE)
`ifdef BENCH_MULTI_ARB_STARVE_EN
          , .MAX_WAIT  (MAX_WAIT)
`endif
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .run      (run_c),
            .wrap     (wrap_c),
            .req      (bus.req[c]),
            .grant    (bus.grant[c]),
            .deny_c   (deny_c[c]),
            .spur_c   (spur_c[c]),
            .starve_c (starve_c[c])
        );
    end

    // More than one grant bit set: clearing the lowest set bit leaves a residue.
    assign mutex_c = (bus.grant & (bus.grant - N_CH'(1))) != '0;
    assign code_c  = err_prio(mutex_c, |spur_c, |deny_c, |starve_c);
    assign viol_c  = (code_c != NONE);

    // FSM, window phase, first-cause capture and busy pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            win        <= '0;
            err_code_q <= NONE;
            busy_q     <= '0;
        end else begin
            busy_q <= bus.req & bus.grant;
            case (state)
                RUN: begin
                    win <= wrap_c ? '0 : win + WIN_W'(1);
                    if (viol_c) begin
                        state      <= FAIL;
                        err_code_q <= code_c;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
            endcase
        end
    end

    assign bus.error    = (state == FAIL);
    assign bus.err_code = err_code_q;
    assign bus.busy     = busy_q;
    assign bus._rt_get  = bus.req;

endmodule

// File: tb/tb_bench_multi_arb_monitor.sv
// Directed bench for bench_multi_arb_monitor; expected outputs are queued per cycle
// and checked by an independent monitor process. Honours BENCH_MULTI_ARB_STARVE_EN.
module tb_bench_multi_arb_monitor;
    import bench_multi_arb_pkg::*;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bench_multi_arb_monitor_if #(.N_CH(N)) bus ();

    bench_multi_arb_monitor #(
        .N_CH      (N),
        .CNT_W     (3),
        .MAX_SERVE (4),
        .WIN_LEN   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic         err;
        logic [2:0]   code;
        logic [N-1:0] busy;
        logic [N-1:0] rt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   sample = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s sample %0d: got %0h expected %0h", name, sample, act, want);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next posedge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] gr,
                        input logic e, input logic [2:0] c);
        exp_t x;
        @(negedge clk);
        rst       = r;
        bus.req   = rq;
        bus.grant = gr;
        x.err  = e;
        x.code = c;
        x.busy = r ? '0 : (rq & gr);
        x.rt   = rq;
        exp_q.push_back(x);
    endtask

    task automatic rep(input int n, input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] gr, input logic e, input logic [2:0] c);
        for (int i = 0; i < n; i++) step(r, rq, gr, e, c);
    endtask

    // Scoreboard monitor: compares whenever a queued expectation is due.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("error",    8'(bus.error),    8'(x.err));
                chk("err_code", 8'(bus.err_code), 8'(x.code));
                chk("busy",     8'(bus.busy),     8'(x.busy));
                chk("rt_get",   8'(bus._rt_get),  8'(x.rt));
                sample++;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus.req   = '0;
        bus.grant = '0;

        // Reset then idle traffic.
        rep(2, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        rep(20, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);

        // Four serves on ch0, then a denial -> DENY; busy keeps tracking in FAIL.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        rep(4, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'd0);
        step(1'b0, 4'b0001, 4'b0000, 1'b1, 3'd3);
        rep(2, 1'b0, 4'b0010, 4'b0010, 1'b1, 3'd3);
        rep(2, 1'b0, 4'b1000, 4'b0000, 1'b1, 3'd3);

        // Reset mid-FAIL (req visible on rt_get during reset); window phase restarts.
        step(1'b1, 4'b1010, 4'b0000, 1'b0, 3'd0);
        rep(12, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
        rep(4, 1'b0, 4'b0010, 4'b0010, 1'b0, 3'd0);
        step(1'b0, 4'b0010, 4'b0000, 1'b0, 3'd0);

        // Wrap clear beats same-cycle serve: ch0 serves 11..18, denied at 19 -> no error.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        rep(11, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
        rep(5, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'd0);
        rep(3, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'd0);
        step(1'b0, 4'b0001, 4'b0000, 1'b0, 3'd0);
        step(1'b0, 4'b0001, 4'b0001, 1'b0, 3'd0);
        step(1'b0, 4'b0001, 4'b0000, 1'b1, 3'd3);

        // MUTEX beats SPUR.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        step(1'b0, 4'b0011, 4'b0111, 1'b1, 3'd1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, 3'd1);

        // Lone SPUR.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        step(1'b0, 4'b0001, 4'b0010, 1'b1, 3'd2);

        // SPUR beats DENY in the same cycle.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        rep(4, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'd0);
        step(1'b0, 4'b0001, 4'b0010, 1'b1, 3'd2);

        // Channel 2 denied repeatedly with cnt=0.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
`ifdef BENCH_MULTI_ARB_STARVE_EN
        rep(2, 1'b0, 4'b0100, 4'b0000, 1'b0, 3'd0);
        rep(2, 1'b0, 4'b0100, 4'b0000, 1'b1, 3'd4);
`else
        rep(4, 1'b0, 4'b0100, 4'b0000, 1'b0, 3'd0);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
